// File: rtl/histogram_accumulator_if.sv
// Pixel-stream / display-read bundle for histogram_accumulator.
//   iValid, iPixel, iFrameEnd : pixel stream and frame delimiter (into the block)
//   iHistoAddr                : display-side bin address (into the block)
//   oHistoValue               : count of the addressed display bin, 1-cycle latency
//   oFrameDone, oFrameCount   : bank-swap pulse and last frame's pixel count
//   oBusy, oOverrun           : not-accepting indicator and sticky drop flag
interface histogram_accumulator_if #(
  parameter int CW = 20
) ();
  logic          iValid;
  logic [7:0]    iPixel;
  logic          iFrameEnd;
  logic [7:0]    iHistoAddr;
  logic [CW-1:0] oHistoValue;
  logic          oFrameDone;
  logic [CW-1:0] oFrameCount;
  logic          oBusy;
  logic          oOverrun;

  modport slave (
    input  iValid, iPixel, iFrameEnd, iHistoAddr,
    output oHistoValue, oFrameDone, oFrameCount, oBusy, oOverrun
  );

  modport master (
    output iValid, iPixel, iFrameEnd, iHistoAddr,
    input  oHistoValue, oFrameDone, oFrameCount, oBusy, oOverrun
  );
endinterface

// File: rtl/histogram_accumulator.sv
// 256-bin luminance histogram with ping-pong banks. One bank accumulates the
// current frame through a 2-stage read-modify-write pipeline while the other
// holds the last completed frame for the display read port.
//   iClk    : system clock, rising edge
//   iRst_n  : synchronous active-low reset
//   bus     : histogram_accumulator_if.slave (pixel stream, frame end,
//             display read port, status outputs)
module histogram_accumulator #(
  parameter int BINS       = 256,
  parameter int CW         = 20,
  parameter int CLR_CYCLES = 256
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  histogram_accumulator_if.slave   bus
);

  localparam int AW = 8;
  localparam logic [AW-1:0] CNT_LAST = AW'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {RESET_CLR, ACCUM, FLUSH, CLEAR} state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_cnt, w_cnt_n;
  logic          w_swap;

  logic [CW-1:0] r_bank0 [BINS];
  logic [CW-1:0] r_bank1 [BINS];

  logic          r_wsel;       // 0: bank0 accumulates, bank1 displayed
  logic          r_p_vld;
  logic [AW-1:0] r_p_addr;
  logic [CW-1:0] r_p_rd;
  logic [CW-1:0] r_pix_cnt;
  logic [CW-1:0] r_frame_cnt;
  logic          r_done;
  logic          r_ovr;
  logic [CW-1:0] r_rd;

  logic          w_accept;
  logic [CW-1:0] w_inc;
  logic [CW-1:0] w_wr_q;
  logic          w_clr_all;
  logic          w_clr_wr;
  logic          w_we0, w_we1;
  logic [AW-1:0] w_waddr;
  logic [CW-1:0] w_wdata;

  // ---------------- FSM ----------------
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= RESET_CLR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_swap    = 1'b0;
    case (r_state)
      RESET_CLR, CLEAR: begin
        if (r_cnt == CNT_LAST) begin
          w_state_n = ACCUM;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      ACCUM: begin
        if (bus.iFrameEnd) begin
          w_state_n = FLUSH;
          w_cnt_n   = '0;
        end
      end
      FLUSH: begin
        if (r_cnt[0]) begin
          w_state_n = CLEAR;
          w_cnt_n   = '0;
          w_swap    = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = RESET_CLR;
    endcase
  end

  // ---------------- bank write port ----------------
  assign w_accept  = (r_state == ACCUM) && bus.iValid;
  assign w_inc     = (&r_p_rd) ? r_p_rd : r_p_rd + 1'b1;
  assign w_wr_q    = r_wsel ? r_bank1[bus.iPixel] : r_bank0[bus.iPixel];
  assign w_clr_all = (r_state == RESET_CLR);
  assign w_clr_wr  = (r_state == CLEAR);
  assign w_waddr   = (w_clr_all || w_clr_wr) ? r_cnt : r_p_addr;
  assign w_wdata   = (w_clr_all || w_clr_wr) ? '0 : w_inc;

  // Writes are gated by iRst_n so a pending pipeline write is discarded on
  // the edge that samples reset.
  assign w_we0 = iRst_n && (w_clr_all || ((r_p_vld || w_clr_wr) && !r_wsel));
  assign w_we1 = iRst_n && (w_clr_all || ((r_p_vld || w_clr_wr) &&  r_wsel));

  always_ff @(posedge iClk) begin
    if (w_we0) r_bank0[w_waddr] <= w_wdata;
    if (w_we1) r_bank1[w_waddr] <= w_wdata;
  end

  // ---------------- pipeline, counters, read port ----------------
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_p_vld     <= 1'b0;
      r_p_addr    <= '0;
      r_p_rd      <= '0;
      r_wsel      <= 1'b0;
      r_pix_cnt   <= '0;
      r_frame_cnt <= '0;
      r_done      <= 1'b0;
      r_ovr       <= 1'b0;
      r_rd        <= '0;
    end else begin
      r_p_vld <= w_accept;
      if (w_accept) begin
        r_p_addr <= bus.iPixel;
        // The stage-2 write of the same bin lands on this edge, so the RAM
        // read is stale; take the value being written instead.
        r_p_rd   <= (r_p_vld && (r_p_addr == bus.iPixel)) ? w_inc : w_wr_q;
      end
      if (w_accept && !(&r_pix_cnt))
        r_pix_cnt <= r_pix_cnt + 1'b1;
      if (w_swap) begin
        r_wsel      <= ~r_wsel;
        r_frame_cnt <= r_pix_cnt;
        r_pix_cnt   <= '0;
      end
      r_done <= w_swap;
      if ((r_state != ACCUM) && (bus.iValid || bus.iFrameEnd))
        r_ovr <= 1'b1;
      r_rd <= r_wsel ? r_bank0[bus.iHistoAddr] : r_bank1[bus.iHistoAddr];
    end
  end

  assign bus.oHistoValue = r_rd;
  assign bus.oFrameDone  = r_done;
  assign bus.oFrameCount = r_frame_cnt;
  assign bus.oBusy       = (r_state != ACCUM);
  assign bus.oOverrun    = r_ovr;

endmodule

// File: tb/tb_histogram_accumulator.sv
// Self-checking bench for histogram_accumulator. Counter width is reduced so
// saturation is reachable in a short run; bins stay at 256.
module tb_histogram_accumulator;

  localparam int CW  = 12;
  localparam int MAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  histogram_accumulator_if #(.CW(CW)) bus ();

  histogram_accumulator #(
    .BINS(256),
    .CW(CW),
    .CLR_CYCLES(256)
  ) dut (
    .iClk(clk),
    .iRst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: histogram of the open frame, histogram on display.
  int exp_acc  [256];
  int exp_disp [256];
  int exp_cnt;
  int exp_fc;
  bit exp_ovr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 256; b++) begin
      exp_acc[b]  = 0;
      exp_disp[b] = 0;
    end
    exp_cnt = 0;
    exp_fc  = 0;
    exp_ovr = 1'b0;
  endtask

  task automatic model_pixel(input int p);
    if (exp_acc[p] < MAX) exp_acc[p] = exp_acc[p] + 1;
    if (exp_cnt < MAX)    exp_cnt    = exp_cnt + 1;
  endtask

  task automatic model_close();
    for (int b = 0; b < 256; b++) begin
      exp_disp[b] = exp_acc[b];
      exp_acc[b]  = 0;
    end
    exp_fc  = exp_cnt;
    exp_cnt = 0;
  endtask

  task automatic send(input logic [7:0] p, input bit v);
    bus.iValid = v;
    bus.iPixel = p;
    if (v) model_pixel(int'(p));
    step();
    bus.iValid = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 256; a++) begin
      bus.iHistoAddr = 8'(a);
      step();
      tests++;
      if (bus.oHistoValue !== exp_disp[a]) begin
        fails++;
        $display("FAIL %s bin %0d: got %0d expected %0d", tag, a, bus.oHistoValue, exp_disp[a]);
      end
    end
  endtask

  task automatic release_reset(input string tag);
    int n;
    rst_n = 1'b1;
    n = 0;
    while (bus.oBusy === 1'b1 && n < 400) begin
      step();
      n++;
    end
    tests++;
    if (n != 256) begin
      fails++;
      $display("FAIL %s busy_len: got %0d expected 256", tag, n);
    end
    tests++;
    if (bus.oOverrun !== 1'b0) begin
      fails++;
      $display("FAIL %s overrun: got %0b expected 0", tag, bus.oOverrun);
    end
    tests++;
    if (bus.oFrameCount !== 0) begin
      fails++;
      $display("FAIL %s frame_count: got %0d expected 0", tag, bus.oFrameCount);
    end
  endtask

  // Closes the frame and walks the FLUSH/CLEAR sequence cycle by cycle.
  task automatic frame_end(input bit with_pix, input logic [7:0] pix,
                           input logic [7:0] probe, input bit drop, input bit late_fe);
    int old_v, new_v, n, extra;
    old_v = exp_disp[probe];
    bus.iFrameEnd  = 1'b1;
    bus.iValid     = with_pix;
    bus.iPixel     = pix;
    bus.iHistoAddr = probe;
    if (with_pix) model_pixel(int'(pix));
    model_close();
    new_v = exp_disp[probe];
    step();                                  // cycle 1
    bus.iFrameEnd = 1'b0;
    bus.iValid    = 1'b0;
    tests++;
    if (bus.oBusy !== 1'b1 || bus.oFrameDone !== 1'b0) begin
      fails++;
      $display("FAIL flush_c1: busy=%0b done=%0b expected busy=1 done=0", bus.oBusy, bus.oFrameDone);
    end
    step();                                  // cycle 2
    tests++;
    if (bus.oFrameDone !== 1'b0) begin
      fails++;
      $display("FAIL flush_c2_done: got %0b expected 0", bus.oFrameDone);
    end
    if (drop) begin
      bus.iValid = 1'b1;
      bus.iPixel = 8'h80;
      exp_ovr    = 1'b1;
    end
    step();                                  // cycle 3
    bus.iValid = 1'b0;
    tests++;
    if (bus.oFrameDone !== 1'b1) begin
      fails++;
      $display("FAIL frame_done: got %0b expected 1", bus.oFrameDone);
    end
    tests++;
    if (bus.oFrameCount !== exp_fc) begin
      fails++;
      $display("FAIL frame_count: got %0d expected %0d", bus.oFrameCount, exp_fc);
    end
    tests++;
    if (bus.oHistoValue !== old_v) begin
      fails++;
      $display("FAIL swap_old bin %0d: got %0d expected %0d", probe, bus.oHistoValue, old_v);
    end
    tests++;
    if (bus.oOverrun !== exp_ovr) begin
      fails++;
      $display("FAIL overrun_c3: got %0b expected %0b", bus.oOverrun, exp_ovr);
    end
    step();                                  // cycle 4
    tests++;
    if (bus.oFrameDone !== 1'b0) begin
      fails++;
      $display("FAIL done_width: got %0b expected 0", bus.oFrameDone);
    end
    tests++;
    if (bus.oHistoValue !== new_v) begin
      fails++;
      $display("FAIL swap_new bin %0d: got %0d expected %0d", probe, bus.oHistoValue, new_v);
    end
    n = 0;
    extra = 0;
    while (bus.oBusy === 1'b1 && n < 400) begin
      if (late_fe && n == 5) begin
        bus.iFrameEnd = 1'b1;
        exp_ovr = 1'b1;
      end
      step();
      bus.iFrameEnd = 1'b0;
      n++;
      if (bus.oFrameDone !== 1'b0) extra++;
    end
    tests++;
    if (n != 255) begin
      fails++;
      $display("FAIL clear_len: got %0d cycles expected 255 after cycle 4", n);
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL extra_done: got %0d pulses expected 0", extra);
    end
    tests++;
    if (bus.oOverrun !== exp_ovr) begin
      fails++;
      $display("FAIL overrun_end: got %0b expected %0b", bus.oOverrun, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests++;
    if (bus.oHistoValue !== 0 || bus.oFrameDone !== 1'b0 || bus.oFrameCount !== 0) begin
      fails++;
      $display("FAIL reset_outputs: value=%0d done=%0b count=%0d expected 0 0 0",
               bus.oHistoValue, bus.oFrameDone, bus.oFrameCount);
    end
    tests++;
    if (bus.oBusy !== 1'b1 || bus.oOverrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: busy=%0b overrun=%0b expected 1 0", bus.oBusy, bus.oOverrun);
    end
    model_reset();
    release_reset("reset");
    read_all("reset_clear");
  endtask

  task automatic test_single_bin();
    for (int i = 0; i < 10; i++) send(8'h40, 1'b1);
    frame_end(1'b0, 8'h00, 8'h40, 1'b0, 1'b0);
    tests++;
    if (bus.oFrameCount !== 10) begin
      fails++;
      $display("FAIL single_count: got %0d expected 10", bus.oFrameCount);
    end
    read_all("single_bin");
  endtask

  task automatic test_hazard();
    logic [7:0] seq [5];
    seq = '{8'd5, 8'd5, 8'd7, 8'd5, 8'd7};
    for (int i = 0; i < 5; i++) send(seq[i], 1'b1);
    send(8'd0, 1'b0);
    send(8'd5, 1'b1);
    frame_end(1'b0, 8'h00, 8'd5, 1'b0, 1'b0);
    bus.iHistoAddr = 8'd5;
    step();
    tests++;
    if (bus.oHistoValue !== 4) begin
      fails++;
      $display("FAIL hazard_bin5: got %0d expected 4", bus.oHistoValue);
    end
    bus.iHistoAddr = 8'd7;
    step();
    tests++;
    if (bus.oHistoValue !== 2) begin
      fails++;
      $display("FAIL hazard_bin7: got %0d expected 2", bus.oHistoValue);
    end
    tests++;
    if (bus.oFrameCount !== 6) begin
      fails++;
      $display("FAIL hazard_count: got %0d expected 6", bus.oFrameCount);
    end
    read_all("hazard");
  endtask

  task automatic test_ping_pong();
    for (int i = 0; i < 3; i++) send(8'h10, 1'b1);
    frame_end(1'b0, 8'h00, 8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b1);
    bus.iHistoAddr = 8'h10;
    step();
    tests++;
    if (bus.oHistoValue !== 3) begin
      fails++;
      $display("FAIL pingpong_during: got %0d expected 3", bus.oHistoValue);
    end
    frame_end(1'b0, 8'h00, 8'h20, 1'b0, 1'b0);
    bus.iHistoAddr = 8'h10;
    step();
    tests++;
    if (bus.oHistoValue !== 0) begin
      fails++;
      $display("FAIL pingpong_old: got %0d expected 0", bus.oHistoValue);
    end
    bus.iHistoAddr = 8'h20;
    step();
    tests++;
    if (bus.oHistoValue !== 1) begin
      fails++;
      $display("FAIL pingpong_new: got %0d expected 1", bus.oHistoValue);
    end
    read_all("ping_pong");
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 200; i++) begin
        logic [7:0] p;
        bit v;
        v = ($urandom_range(0, 3) != 0);
        p = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        send(p, v);
      end
      frame_end(1'b1, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 1'b0, 1'b0);
      read_all("random");
    end
  endtask

  task automatic test_busy_drop();
    send(8'h81, 1'b1);
    send(8'h81, 1'b1);
    frame_end(1'b0, 8'h00, 8'h80, 1'b1, 1'b1);
    send(8'h81, 1'b1);
    send(8'h82, 1'b1);
    frame_end(1'b0, 8'h00, 8'h80, 1'b0, 1'b0);
    bus.iHistoAddr = 8'h80;
    step();
    tests++;
    if (bus.oHistoValue !== 0) begin
      fails++;
      $display("FAIL drop_bin80: got %0d expected 0", bus.oHistoValue);
    end
    read_all("busy_drop");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < MAX + 5; i++) send(8'h00, 1'b1);
    frame_end(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tests++;
    if (bus.oFrameCount !== MAX) begin
      fails++;
      $display("FAIL sat_count: got %0d expected %0d", bus.oFrameCount, MAX);
    end
    read_all("saturation");
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 15)), 1'b1);
    bus.iValid = 1'b1;
    bus.iPixel = 8'h33;
    step();
    bus.iValid = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    model_reset();
    release_reset("abort");
    read_all("abort_clear");
    for (int i = 0; i < 5; i++) send(8'h33, 1'b1);
    frame_end(1'b0, 8'h00, 8'h33, 1'b0, 1'b0);
    read_all("after_abort");
  endtask

  initial begin
    bus.iValid     = 1'b0;
    bus.iPixel     = '0;
    bus.iFrameEnd  = 1'b0;
    bus.iHistoAddr = '0;
    test_reset();
    test_single_bin();
    test_hazard();
    test_ping_pong();
    test_random();
    test_busy_drop();
    test_saturation();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/histogram_accumulator.md
# histogram_accumulator

Builds the 256-bin luminance histogram that the on-screen histogram overlay reads. Consumes the 8-bit pixel stream and increments one 20-bit bin per valid pixel. Uses two ping-pong banks: one accumulates the current frame while the other holds the last completed frame for the display read port. Sits between the grayscale pixel pipeline and the histogram display overlay, replacing the standalone histogram RAM.

## Interface
Parameters:
- BINS, 256, number of bins; fixed, address width 8.
- CW, 20, bin counter width.
- CLR_CYCLES, 256, cycles spent clearing a bank (one bin per cycle).

Ports:
- iClk  in  1  system clock; all logic is on the rising edge.
- iRst_n  in  1  reset; **synchronous, active-low**.
- iValid  in  1  qualifies iPixel.
- iPixel  in  8  pixel value; selects the bin to increment.
- iFrameEnd  in  1  one-cycle pulse; closes the current frame.
- iHistoAddr  in  8  display-side read address.
- oHistoValue  out  20  count of bin iHistoAddr, taken from the display bank.
- oFrameDone  out  1  one-cycle pulse; banks have just swapped.
- oFrameCount  out  20  number of pixels accumulated in the last completed frame (saturating).
- oBusy  out  1  high during FLUSH and CLEAR; pixels are not accepted.
- oOverrun  out  1  sticky error flag; cleared only by reset.

## Operation
- States are RESET_CLR, ACCUM, FLUSH and CLEAR.
- **RESET_CLR:** entered whenever iRst_n=0 is sampled.
  - Clears both banks, bin k at cycle k after release, for 256 cycles.
  - Then moves to ACCUM.
- **ACCUM:**
  - Each iValid=1 cycle increments bin iPixel of the write bank and increments the frame pixel counter.
  - Both bins and the pixel counter saturate at 0xFFFFF.
- **Read-modify-write pipeline:**
  - Stage 1 issues a read of bin iPixel.
  - Stage 2 adds 1 and writes the result.
  - When the stage-1 bin equals the stage-2 bin, stage 1 uses the forwarded stage-2 result, not the RAM data.
  - Counts must be exact for any input sequence, including back-to-back identical pixels and patterns such as A,B,A.
- **iFrameEnd in ACCUM:**
  - A pixel with iValid=1 in the same cycle belongs to the ending frame.
  - Goes to FLUSH for 2 cycles so the pipeline drains.
  - At the end of FLUSH:
    - the write and display banks swap;
    - oFrameCount is loaded from the pixel counter;
    - the pixel counter is cleared;
    - oFrameDone pulses.
  - Then goes to CLEAR.
- **CLEAR:** zeroes the new write bank, one bin per cycle for 256 cycles, then returns to ACCUM.
- **Error cases:**
  - iValid=1 while oBusy=1: the pixel is dropped and oOverrun is set.
  - iFrameEnd while oBusy=1: ignored, and oOverrun is set.
- **Read port:**
  - Reads only the display bank and is independent of the accumulation state.
  - The display bank is never written, except during RESET_CLR.

## Timing
- **Reset values:**
  - oHistoValue=0, oFrameDone=0, oFrameCount=0, oOverrun=0, oBusy=1.
  - All bins read 0 once RESET_CLR completes.
- **Read latency:** oHistoValue is valid 1 cycle after iHistoAddr is sampled.
- **Reset timing:**
  - oBusy falls on the 257th cycle after the first cycle with iRst_n=1.
  - The first pixel is accepted in that cycle.
- **Frame-end sequence** (iFrameEnd sampled in cycle 0):
  - FLUSH runs in cycles 1–2.
  - Banks swap at the cycle-2 edge.
  - oFrameDone=1 and the new oFrameCount appear in cycle 3.
  - CLEAR runs in cycles 3–258.
  - oBusy=0 and ACCUM resume in cycle 259.
- **Bank swap:** an address sampled in cycle 3 or later returns new-bank data (visible from cycle 4). An address sampled in cycle 2 returns old-bank data.
- **Reset mid-operation:**
  - Any state aborts to RESET_CLR.
  - In-flight pipeline writes are discarded.
  - The bank select returns to bank 0 accumulating and bank 1 displayed.
- **Minimum blanking:** at least 259 cycles between iFrameEnd and the next valid pixel. Shorter gaps cause drops that are flagged by oOverrun.

## Test plan
- **Reset clear:** reset, then read addresses 0..255 after oBusy falls -> all 0. oBusy falls exactly 256 cycles after release, and oOverrun=0.
- **Single-bin run:** 10 back-to-back pixels of 0x40, then iFrameEnd -> oFrameDone in cycle 3. Bin 0x40 reads 10, all other bins read 0, oFrameCount=10.
- **Hazard pattern:** pixels 5,5,7,5,7 back-to-back, then 5 with a one-cycle gap, then iFrameEnd -> bin 5 = 4, bin 7 = 2, oFrameCount=6.
- **Ping-pong:** frame A has 3×0x10; frame B has 1×0x20 and ends. Reading during frame B returns bin 0x10=3. After the second oFrameDone, bin 0x10=0 and bin 0x20=1.
- **Busy drop:** pixel 0x80 with iValid=1 two cycles after iFrameEnd -> oOverrun=1. Bin 0x80 in the next completed frame is 0.
- **Saturation and reset abort:**
  - 1,048,580 pixels of 0x00 -> bin 0 = 0xFFFFF and oFrameCount = 0xFFFFF.
  - Assert iRst_n=0 mid-frame -> after RESET_CLR all bins read 0 and oFrameCount=0.
